// File: rtl/gpu_cmd_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_cmd_loader                                                       |
// | Command-stream parser: BRAM pixel writes plus tear-free blob/bg      |
// | settings. Optional macro GPU_CMD_IMMEDIATE_EN adds opcode 0x5.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gpu_cmd_loader #(
  parameter int ram_add_width = 8,
  parameter int NR_OF_BLOBS   = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [15:0]                              cmd_data,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic                                     v_sync,
  output logic [11:0]                              background,
  output logic [NR_OF_BLOBS-1:0]                   sprite_enable,
  output logic [NR_OF_BLOBS-1:0][9:0]              y1_pos,
  output logic [NR_OF_BLOBS-1:0][9:0]              x1_pos,
  output logic [NR_OF_BLOBS-1:0][9:0]              height,
  output logic [NR_OF_BLOBS-1:0][9:0]              width,
  output logic [NR_OF_BLOBS-1:0][ram_add_width-1:0] ram_address,
  output logic [NR_OF_BLOBS-1:0][1:0]              layer,
  output logic [ram_add_width-1:0]                 wr_add,
  output logic [11:0]                              wr_data,
  output logic                                     wr_req,
  output logic                                     commit_pending,
  output logic                                     cmd_error
);

  localparam logic [2:0] c_st_hdr      = 3'd0;
  localparam logic [2:0] c_st_blob     = 3'd1;
  localparam logic [2:0] c_st_pix_addr = 3'd2;
  localparam logic [2:0] c_st_pix_data = 3'd3;
  localparam logic [2:0] c_st_bg       = 3'd4;
  localparam logic [2:0] c_st_wait_vs  = 3'd5;

  localparam logic [3:0] c_op_blob   = 4'h1;
  localparam logic [3:0] c_op_pix    = 4'h2;
  localparam logic [3:0] c_op_bg     = 4'h3;
  localparam logic [3:0] c_op_commit = 4'h4;
`ifdef GPU_CMD_IMMEDIATE_EN
  localparam logic [3:0] c_op_now    = 4'h5;
`endif

  logic [2:0]               r_state;
  logic [2:0]               w_state_nxt;
  logic                     w_accept;
  logic [3:0]               w_op;
  logic                     w_op_legal;
  logic                     w_idx_ok;
  logic                     r_vs_q;
  logic                     w_vs_fall;
  logic                     w_commit;
  logic [2:0]               r_blob_cnt;
  logic [3:0]               r_blob_idx;
  logic                     r_blob_ok;
  logic [11:0]              r_pix_cnt;
  logic [ram_add_width-1:0] r_pix_addr;
  logic [ram_add_width-1:0] r_wr_add;
  logic [11:0]              r_wr_data;
  logic                     r_wr_req;
  logic                     r_err;
  logic [11:0]              r_sh_bg;
  logic [11:0]              r_act_bg;

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_op      = cmd_data[15:12];
  assign w_idx_ok  = ({1'b0, cmd_data[3:0]} < 5'(NR_OF_BLOBS));
  assign w_vs_fall = r_vs_q & ~v_sync;

`ifdef GPU_CMD_IMMEDIATE_EN
  logic r_commit_now;
  assign w_commit = ((r_state == c_st_wait_vs) && w_vs_fall) || r_commit_now;
`else
  assign w_commit = (r_state == c_st_wait_vs) && w_vs_fall;
`endif

  always_comb begin
    w_op_legal = 1'b0;
    case (w_op)
      c_op_blob, c_op_pix, c_op_bg, c_op_commit: w_op_legal = 1'b1;
`ifdef GPU_CMD_IMMEDIATE_EN
      c_op_now: w_op_legal = 1'b1;
`endif
      default: w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_hdr;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_hdr: begin
        if (w_accept) begin
          case (w_op)
            c_op_blob:   w_state_nxt = c_st_blob;
            c_op_pix:    w_state_nxt = c_st_pix_addr;
            c_op_bg:     w_state_nxt = c_st_bg;
            c_op_commit: w_state_nxt = c_st_wait_vs;
            default:     w_state_nxt = c_st_hdr;
          endcase
        end
      end
      c_st_blob:     if (w_accept && (r_blob_cnt == 3'd5)) w_state_nxt = c_st_hdr;
      c_st_pix_addr: if (w_accept) w_state_nxt = (r_pix_cnt == 12'd0) ? c_st_hdr : c_st_pix_data;
      c_st_pix_data: if (w_accept && (r_pix_cnt == 12'd1)) w_state_nxt = c_st_hdr;
      c_st_bg:       if (w_accept) w_state_nxt = c_st_hdr;
      c_st_wait_vs:  if (w_vs_fall) w_state_nxt = c_st_hdr;
      default:       w_state_nxt = c_st_hdr;
    endcase
  end

  always_comb begin
    cmd_ready      = (r_state != c_st_wait_vs);
    commit_pending = (r_state == c_st_wait_vs);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_q     <= 1'b0;
      r_blob_cnt <= '0;
      r_blob_idx <= '0;
      r_blob_ok  <= 1'b0;
      r_pix_cnt  <= '0;
      r_pix_addr <= '0;
      r_wr_add   <= '0;
      r_wr_data  <= '0;
      r_wr_req   <= 1'b0;
      r_err      <= 1'b0;
      r_sh_bg    <= '0;
      r_act_bg   <= '0;
    end else begin
      r_vs_q   <= v_sync;
      r_wr_req <= 1'b0;
      if (w_accept) begin
        case (r_state)
          c_st_hdr: begin
            r_blob_cnt <= '0;
            r_blob_idx <= cmd_data[3:0];
            r_blob_ok  <= w_idx_ok;
            r_pix_cnt  <= cmd_data[11:0];
            if (!w_op_legal || ((w_op == c_op_blob) && !w_idx_ok)) r_err <= 1'b1;
          end
          c_st_blob:     r_blob_cnt <= r_blob_cnt + 3'd1;
          c_st_pix_addr: r_pix_addr <= cmd_data[ram_add_width-1:0];
          c_st_pix_data: begin
            r_wr_req   <= 1'b1;
            r_wr_add   <= r_pix_addr;
            r_wr_data  <= cmd_data[11:0];
            r_pix_addr <= r_pix_addr + ram_add_width'(1);
            r_pix_cnt  <= r_pix_cnt - 12'd1;
          end
          c_st_bg:       r_sh_bg <= cmd_data[11:0];
          default: ;
        endcase
      end
      if (w_commit) r_act_bg <= r_sh_bg;
    end
  end

`ifdef GPU_CMD_IMMEDIATE_EN
  // One-cycle delayed copy so the header itself never races a shadow write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_commit_now <= 1'b0;
    else        r_commit_now <= w_accept && (r_state == c_st_hdr) && (w_op == c_op_now);
  end
`endif

  for (genvar b = 0; b < NR_OF_BLOBS; b++) begin : g_blob
    logic [9:0]               r_sh_y1, r_sh_x1, r_sh_h, r_sh_w;
    logic [9:0]               r_act_y1, r_act_x1, r_act_h, r_act_w;
    logic [ram_add_width-1:0] r_sh_ra, r_act_ra;
    logic                     r_sh_en, r_act_en;
    logic [1:0]               r_sh_layer, r_act_layer;
    logic                     w_we;

    assign w_we = w_accept && (r_state == c_st_blob) && r_blob_ok && (r_blob_idx == 4'(b));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sh_y1     <= '0;
        r_sh_x1     <= '0;
        r_sh_h      <= '0;
        r_sh_w      <= '0;
        r_sh_ra     <= '0;
        r_sh_en     <= 1'b0;
        r_sh_layer  <= '0;
        r_act_y1    <= '0;
        r_act_x1    <= '0;
        r_act_h     <= '0;
        r_act_w     <= '0;
        r_act_ra    <= '0;
        r_act_en    <= 1'b0;
        r_act_layer <= '0;
      end else begin
        if (w_we) begin
          case (r_blob_cnt)
            3'd0: r_sh_y1 <= cmd_data[9:0];
            3'd1: r_sh_x1 <= cmd_data[9:0];
            3'd2: r_sh_h  <= cmd_data[9:0];
            3'd3: r_sh_w  <= cmd_data[9:0];
            3'd4: r_sh_ra <= cmd_data[ram_add_width-1:0];
            3'd5: begin
              r_sh_en    <= cmd_data[0];
              r_sh_layer <= cmd_data[2:1];
            end
            default: ;
          endcase
        end
        if (w_commit) begin
          r_act_y1    <= r_sh_y1;
          r_act_x1    <= r_sh_x1;
          r_act_h     <= r_sh_h;
          r_act_w     <= r_sh_w;
          r_act_ra    <= r_sh_ra;
          r_act_en    <= r_sh_en;
          r_act_layer <= r_sh_layer;
        end
      end
    end

    assign y1_pos[b]        = r_act_y1;
    assign x1_pos[b]        = r_act_x1;
    assign height[b]        = r_act_h;
    assign width[b]         = r_act_w;
    assign ram_address[b]   = r_act_ra;
    assign sprite_enable[b] = r_act_en;
    assign layer[b]         = r_act_layer;
  end

  assign background = r_act_bg;
  assign wr_add     = r_wr_add;
  assign wr_data    = r_wr_data;
  assign wr_req     = r_wr_req;
  assign cmd_error  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_loader.sv
`default_nettype none
// tb_gpu_cmd_loader: directed + randomized command streams checked against a
// command-level model of shadow/active settings and expected BRAM writes.
module tb_gpu_cmd_loader;
  localparam int AW = 8;
  localparam int NB = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [15:0]          cmd_data = '0;
  logic                 cmd_valid = 1'b0;
  logic                 v_sync = 1'b1;
  logic                 cmd_ready;
  logic [11:0]          background;
  logic [NB-1:0]        sprite_enable;
  logic [NB-1:0][9:0]   y1_pos, x1_pos, height, width;
  logic [NB-1:0][AW-1:0] ram_address;
  logic [NB-1:0][1:0]   layer;
  logic [AW-1:0]        wr_add;
  logic [11:0]          wr_data;
  logic                 wr_req, commit_pending, cmd_error;

  gpu_cmd_loader #(.ram_add_width(AW), .NR_OF_BLOBS(NB)) dut (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .v_sync(v_sync), .background(background),
    .sprite_enable(sprite_enable), .y1_pos(y1_pos), .x1_pos(x1_pos),
    .height(height), .width(width), .ram_address(ram_address), .layer(layer),
    .wr_add(wr_add), .wr_data(wr_data), .wr_req(wr_req),
    .commit_pending(commit_pending), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0]    y1, x1, h, w;
    logic [AW-1:0] ra;
    logic          en;
    logic [1:0]    ly;
  } blob_t;
  typedef struct packed {
    int            c;
    logic [AW-1:0] a;
    logic [11:0]   d;
  } wr_t;

  blob_t       m_sh [NB];
  blob_t       m_act[NB];
  logic [11:0] m_sh_bg, m_bg;
  logic        m_err;
  wr_t         exp_q[$];
  wr_t         got_q[$];
  logic [15:0] pq[$];
  logic [15:0] bp[6];
  int          checks = 0;
  int          failures = 0;
  bit          gaps = 0;
  int          last_acc = 0;

  always @(negedge clk) begin
    wr_t w;
    if (wr_req === 1'b1) begin
      w.c = cyc; w.a = wr_add; w.d = wr_data;
      got_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin m_sh[b] = '0; m_act[b] = '0; end
    m_sh_bg = '0; m_bg = '0; m_err = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); cmd_valid = 1'b0; cmd_data = 16'($urandom);
      end
    end
    @(negedge clk);
    cmd_data = w; cmd_valid = 1'b1; n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checks++;
    assert (n < 64) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected=<64", n);
    end
    last_acc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic blob_cmd(input logic [3:0] idx);
    send(16'h1000 | {12'h0, idx});
    for (int i = 0; i < 6; i++) send(bp[i]);
    if (int'(idx) < NB) begin
      m_sh[idx].y1 = bp[0][9:0];
      m_sh[idx].x1 = bp[1][9:0];
      m_sh[idx].h  = bp[2][9:0];
      m_sh[idx].w  = bp[3][9:0];
      m_sh[idx].ra = bp[4][AW-1:0];
      m_sh[idx].en = bp[5][0];
      m_sh[idx].ly = bp[5][2:1];
    end else m_err = 1'b1;
  endtask

  task automatic rand_bp();
    for (int i = 0; i < 6; i++) bp[i] = 16'($urandom);
  endtask

  task automatic bg_cmd(input logic [15:0] v);
    send(16'h3000); send(v); m_sh_bg = v[11:0];
  endtask

  task automatic pix_cmd(input logic [15:0] aw);
    logic [AW-1:0] a;
    wr_t e;
    send(16'h2000 | 16'(pq.size()));
    send(aw);
    a = aw[AW-1:0];
    foreach (pq[i]) begin
      send(pq[i]);
      e.c = last_acc + 1; e.a = a; e.d = pq[i][11:0];
      exp_q.push_back(e);
      a = a + 1'b1;
    end
  endtask

  task automatic flush_writes(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), got_q[i].c, exp_q[i].c);
      chk($sformatf("%s_add%0d", tag, i), got_q[i].a, exp_q[i].a);
      chk($sformatf("%s_dat%0d", tag, i), got_q[i].d, exp_q[i].d);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic check_active(input string tag);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s_b%0d_y1", tag, b), y1_pos[b], m_act[b].y1);
      chk($sformatf("%s_b%0d_x1", tag, b), x1_pos[b], m_act[b].x1);
      chk($sformatf("%s_b%0d_h", tag, b), height[b], m_act[b].h);
      chk($sformatf("%s_b%0d_w", tag, b), width[b], m_act[b].w);
      chk($sformatf("%s_b%0d_ra", tag, b), ram_address[b], m_act[b].ra);
      chk($sformatf("%s_b%0d_en", tag, b), sprite_enable[b], m_act[b].en);
      chk($sformatf("%s_b%0d_ly", tag, b), layer[b], m_act[b].ly);
    end
    chk({tag, "_bg"}, background, m_bg);
    chk({tag, "_err"}, cmd_error, m_err);
  endtask

  task automatic do_commit(input bit same_edge);
    @(negedge clk);
    chk("commit_hdr_ready", cmd_ready, 1);
    cmd_data = 16'h4000; cmd_valid = 1'b1;
    if (same_edge) v_sync = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wait_pending", commit_pending, 1);
      chk("wait_ready_low", cmd_ready, 0);
    end
    check_active("pre_commit");
    v_sync = 1'b1;
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    for (int b = 0; b < NB; b++) m_act[b] = m_sh[b];
    m_bg = m_sh_bg;
    chk("post_pending", commit_pending, 0);
    chk("post_ready", cmd_ready, 1);
    check_active("post_commit");
    v_sync = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_active("in_reset");
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_add", wr_add, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pending", commit_pending, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    // Back-to-back pixel writes
    pq.delete(); pq.push_back(16'h0ABC); pq.push_back(16'h0DEF); pq.push_back(16'h0123);
    pix_cmd(16'h0010);
    flush_writes("pix3");
    check_active("after_pix");

    // Address wrap
    pq.delete(); pq.push_back(16'($urandom)); pq.push_back(16'($urandom));
    pix_cmd(16'h00FF);
    flush_writes("wrap");

    // Zero-length write, then a single write to prove the next header parses
    pq.delete();
    pix_cmd(16'h0033);
    pq.push_back(16'($urandom));
    pix_cmd(16'h0077);
    flush_writes("n0");

    // Directed blob 1 with tear-free commit
    bp = '{16'd100, 16'd200, 16'd32, 16'd16, 16'h0040, 16'h0005};
    blob_cmd(4'd1);
    do_commit(1'b0);
    chk("b1_y1", y1_pos[1], 100);
    chk("b1_layer", layer[1], 2);

    // Out-of-range index and illegal opcode
    rand_bp();
    blob_cmd(4'd7);
    send(16'hF000); m_err = 1'b1;
    @(negedge clk);
    chk("err_sticky", cmd_error, 1);
    bg_cmd(16'h0F00);
    do_commit(1'b0);
    chk("bg_f00", background, 12'hF00);

    // v_sync edge coincident with COMMIT acceptance is ignored
    rand_bp(); blob_cmd(4'd3);
    bg_cmd(16'($urandom));
    do_commit(1'b1);

    // Randomized commands with valid gaps
    gaps = 1;
    for (int k = 0; k < 6; k++) begin
      rand_bp(); blob_cmd(4'($urandom_range(0, NB - 1)));
      if ($urandom_range(0, 1) == 1) bg_cmd(16'($urandom));
      pq.delete();
      repeat ($urandom_range(0, 4)) pq.push_back(16'($urandom));
      pix_cmd(16'($urandom));
      flush_writes($sformatf("rnd%0d", k));
      do_commit(1'b0);
    end

    // Reset in the middle of a SET_BLOB
    rand_bp();
    send(16'h1002); send(bp[0]); send(bp[1]); send(bp[2]);
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    model_reset();
    #1;
    check_active("mid_reset");
    @(negedge clk);
    reset = 1'b1; gaps = 0;
    @(negedge clk);
    chk("rr_pending", commit_pending, 0);
    chk("rr_wr_req", wr_req, 0);
    chk("rr_ready", cmd_ready, 1);
    rand_bp(); blob_cmd(4'd2);
    do_commit(1'b0);

    // COMMIT_NOW opcode
    bg_cmd(16'h00F0);
    send(16'h5000);
`ifdef GPU_CMD_IMMEDIATE_EN
    @(negedge clk);
    chk("now_ready", cmd_ready, 1);
    chk("now_bg_early", background, m_bg);
    @(negedge clk);
    for (int b = 0; b < NB; b++) m_act[b] = m_sh[b];
    m_bg = m_sh_bg;
    check_active("now");
    chk("now_bg", background, 12'h0F0);
`else
    m_err = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_active("now_illegal");
    chk("now_err", cmd_error, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
